// File: rtl/draw_rect.sv
// Rectangle overlay stage: latches position on vsync rise, composites a solid
// rectangle over rgb_in with a fixed 2-cycle latency. Optional border: DRAW_RECT_BORDER_EN.
module draw_rect #(
    parameter int          RECT_W       = 48,
    parameter int          RECT_H       = 64,
    parameter logic [11:0] RECT_COLOR   = 12'hF80,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF,
    parameter int          H_ACTIVE     = 800,
    parameter int          V_ACTIVE     = 600
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out,
    output logic [11:0] rgb_out
);
    localparam logic [11:0] X_MAX = 12'(H_ACTIVE - RECT_W);
    localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - RECT_H);
    localparam logic [12:0] W13   = 13'(RECT_W);
    localparam logic [12:0] H13   = 13'(RECT_H);

    logic        vs_prev_q, armed_q;
    logic [11:0] x_lat_q, y_lat_q;
    logic        vs_rise;

    // armed_q blocks a false edge when vsync is already high as reset releases
    assign vs_rise = vsync_in & ~vs_prev_q & armed_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            x_lat_q   <= '0;
            y_lat_q   <= '0;
        end else begin
            vs_prev_q <= vsync_in;
            armed_q   <= armed_q | ~vsync_in;
            if (vs_rise) begin
                x_lat_q <= (xpos > X_MAX) ? X_MAX : xpos;
                y_lat_q <= (ypos > Y_MAX) ? Y_MAX : ypos;
            end
        end
    end

    logic [12:0] x_end, y_end;
    logic        in_h, in_v, inside_d;
    assign x_end    = {1'b0, x_lat_q} + W13;
    assign y_end    = {1'b0, y_lat_q} + H13;
    assign in_h     = (hcount_in >= x_lat_q) && ({1'b0, hcount_in} < x_end);
    assign in_v     = (vcount_in >= y_lat_q) && ({1'b0, vcount_in} < y_end);
    assign inside_d = in_h && in_v;

    logic [11:0] hcount_q, vcount_q, rgb_q;
    logic        hs_q, vs_q, blank_q, inside_q;
`ifdef DRAW_RECT_BORDER_EN
    logic border_d, border_q;
    assign border_d = inside_d &&
        ((hcount_in == x_lat_q) || ({1'b0, hcount_in} == x_end - 13'd1) ||
         (vcount_in == y_lat_q) || ({1'b0, vcount_in} == y_end - 13'd1));
`endif

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            blank_q  <= 1'b0;
            rgb_q    <= '0;
            inside_q <= 1'b0;
`ifdef DRAW_RECT_BORDER_EN
            border_q <= 1'b0;
`endif
        end else begin
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
            hs_q     <= hsync_in;
            vs_q     <= vsync_in;
            blank_q  <= hblnk_in | vblnk_in;
            rgb_q    <= rgb_in;
            inside_q <= inside_d;
`ifdef DRAW_RECT_BORDER_EN
            border_q <= border_d;
`endif
        end
    end

    logic [11:0] fill_c;
`ifdef DRAW_RECT_BORDER_EN
    assign fill_c = border_q ? BORDER_COLOR : RECT_COLOR;
`else
    assign fill_c = RECT_COLOR;
`endif

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            blank_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_q;
            vcount_out <= vcount_q;
            hs_out     <= hs_q;
            vs_out     <= vs_q;
            blank_out  <= blank_q;
            if (blank_q)       rgb_out <= 12'h000;
            else if (inside_q) rgb_out <= fill_c;
            else               rgb_out <= rgb_q;
        end
    end
endmodule

// File: doc/draw_rect.md
# draw_rect

Pixel-pipeline stage that overlays a solid rectangle onto the background video stream, directly upstream of the mouse-cursor/sync-delay output stage. It consumes the timing bus (counters, syncs, blanking) and background colour, and emits the `vs`/`hs`/`blank`/`rgb`/`hcount`/`vcount` bundle that the cursor stage takes as input. The rectangle position is latched once per frame so the rectangle never tears. All outputs are aligned to each other with a fixed 2-cycle latency.

## Interface

Parameters:
- `RECT_W`, 48: rectangle width in pixels, 2..H_ACTIVE.
- `RECT_H`, 64: rectangle height in pixels, 2..V_ACTIVE.
- `RECT_COLOR`, 12'hF80: fill colour, RGB444.
- `BORDER_COLOR`, 12'hFFF: border colour; used only with the border feature (see Configuration).
- `H_ACTIVE`, 800: visible pixels per line.
- `V_ACTIVE`, 600: visible lines per frame.

Ports:
- `pclk` in 1: pixel clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `hcount_in` in 12: horizontal pixel counter.
- `vcount_in` in 12: vertical line counter.
- `hsync_in` in 1: horizontal sync.
- `vsync_in` in 1: vertical sync.
- `hblnk_in` in 1: horizontal blanking.
- `vblnk_in` in 1: vertical blanking.
- `rgb_in` in 12: background colour {R,G,B}.
- `xpos` in 12: requested rectangle left edge.
- `ypos` in 12: requested rectangle top edge.
- `hcount_out` out 12: `hcount_in` delayed by 2 cycles.
- `vcount_out` out 12: `vcount_in` delayed by 2 cycles.
- `hs_out` out 1: `hsync_in` delayed by 2 cycles.
- `vs_out` out 1: `vsync_in` delayed by 2 cycles.
- `blank_out` out 1: `hblnk_in | vblnk_in`, delayed by 2 cycles.
- `rgb_out` out 12: composited colour.

## Operation

Position latch:
- `vs_prev` holds last-cycle `vsync_in`.
- On the cycle where `vsync_in=1` and `vs_prev=0`:
  - `x_lat <= min(xpos, H_ACTIVE-RECT_W)`
  - `y_lat <= min(ypos, V_ACTIVE-RECT_H)`
- Comparisons are unsigned. `xpos`/`ypos` changes at any other time are ignored until the next vsync rising edge.

Stage 1 (registered):
- Delay counters, syncs and `blank = hblnk_in|vblnk_in`; delay `rgb_in`.
- `in_h = (hcount_in >= x_lat) && (hcount_in < x_lat+RECT_W)`, sum computed in 13 bits (no wrap).
- `in_v` is computed the same way with `vcount_in`, `y_lat` and `RECT_H`.
- `inside = in_h && in_v`.

Stage 2 (registered), priority order:
- `blank` → `rgb_out=12'h000`.
- `inside` → `RECT_COLOR`.
- otherwise → delayed `rgb_in`.
- Delayed timing signals pass through unchanged.

Reset:
- On `rst`: all outputs, pipeline registers, `x_lat`, `y_lat` and `vs_prev` go to 0 immediately. No clock is required.
- Reset mid-frame: outputs hold 0 while `rst=1`. After release, valid data appears from the 2nd rising edge. The rectangle sits at (0,0) until the first vsync rising edge after release.
- If `vsync_in` is already high at release, no edge is detected until it falls and rises again.

## Timing

- Latency is exactly 2 `pclk` cycles, input to output, for every output. There is no handshake or backpressure; a new pixel is accepted every cycle.
- Position takes effect on the first pixel after the vsync rising edge that latched it, i.e. the next frame's active area.
- Rectangle boundaries are inclusive at `x_lat`/`y_lat` and exclusive at `x_lat+RECT_W`/`y_lat+RECT_H`.

## Configuration

- `DRAW_RECT_BORDER_EN` defined: a pixel inside the rectangle whose `hcount` is `x_lat` or `x_lat+RECT_W-1`, or whose `vcount` is `y_lat` or `y_lat+RECT_H-1`, gets `BORDER_COLOR`. All other inside pixels get `RECT_COLOR`. Border flags are computed in stage 1, so latency is unchanged.
- Not defined: every inside pixel gets `RECT_COLOR`, and `BORDER_COLOR` is unused.

## Test plan

- Defaults; `xpos=100`, `ypos=50`, vsync edge, then sweep line `vcount=50`: `rgb_out=12'hF80` for `hcount_out` 100..147, background at 99 and 148, exactly 2 cycles after the matching input.
- `xpos=790`, `ypos=590` latched: clamped to `x_lat=752`, `y_lat=536`; the rectangle ends at pixel 799 and line 599.
- Change `xpos` from 100 to 300 mid-frame: the rest of the frame still draws at 100; the frame after the next vsync rising edge draws at 300.
- Pixel inside the rectangle with `hblnk_in=1`: `rgb_out=12'h000`, `blank_out=1`.
- Assert `rst` mid-line: all outputs 0 asynchronously (before any clock edge). After release, the rectangle draws at (0,0) until the next vsync edge.
- `DRAW_RECT_BORDER_EN` set, rectangle at (100,50): (100,60) and (120,50) give `12'hFFF`; (120,60) gives `12'hF80`.
